pc_sequencer_32: RTL and testbench

- Next-PC controller for the single-cycle MIPS core. Owns the 32-bit PC register and chooses each cycle between sequential, branch, jump, jump-register and trap-vector targets.
- Sequences boot after reset and stalls, and traps on misaligned register targets.
- Feeds instruction memory with the current PC; takes redirect requests from the control unit and ALU zero/compare logic.

---
 rtl/pc_sequencer_32.sv | 147 ++++++++++++++
 tb/tb_pc_sequencer_32.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer_32.sv
// pc_sequencer_32: next-PC controller for the single-cycle MIPS core.
// Owns the PC register and picks each cycle between sequential, branch,
// jump, jump-register and trap-vector targets. A BOOT cycle follows reset
// and a one-cycle TRAP bubble follows every trap entry.
// Optional build macro PC_SEQ_TRACE_EN adds a redirect counter output and a
// simulation-only redirect trace message.
`timescale 1ns/1ps

module pc_sequencer_32 #(
  parameter logic [31:0] RESET_VEC = 32'h0000_0000,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_addr,
  input  logic        exc,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_valid,
  output logic [31:0] epc,
  output logic        misalign
`ifdef PC_SEQ_TRACE_EN
  ,
  output logic [31:0] redirect_count
`endif
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  state_t state;

  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        jr_misaligned;
  logic        jr_trap;

  // Candidate targets are built from pc only, so pc_plus4 never sees inputs.
  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + {{14{branch_imm[15]}}, branch_imm, 2'b00};
  assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
  assign jr_misaligned = (jr_addr[1:0] != 2'b00);
  // A stalled jr is dropped, so it can only fault when the pipe advances.
  assign jr_trap       = jr && !stall && jr_misaligned;

  // Sequencer FSM: owns pc, epc, misalign and fetch_valid as registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= BOOT;
      pc          <= RESET_VEC;
      epc         <= 32'h0000_0000;
      misalign    <= 1'b0;
      fetch_valid <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          pc          <= RESET_VEC;
          fetch_valid <= 1'b1;
          state       <= RUN;
        end
        RUN: begin
          if (exc || jr_trap) begin
            epc         <= pc;
            misalign    <= !exc;
            pc          <= EXC_VEC;
            fetch_valid <= 1'b0;
            state       <= TRAP;
          end else if (!stall) begin
            fetch_valid <= 1'b1;
            if (jr) begin
              pc <= jr_addr;
            end else if (jump) begin
              pc <= jump_target;
            end else if (branch_taken) begin
              pc <= branch_target;
            end else begin
              pc <= pc_plus4;
            end
          end else begin
            fetch_valid <= 1'b1;
          end
        end
        TRAP: begin
          fetch_valid <= 1'b1;
          state       <= RUN;
        end
        default: begin
          pc          <= RESET_VEC;
          fetch_valid <= 1'b0;
          state       <= BOOT;
        end
      endcase
    end
  end

`ifdef PC_SEQ_TRACE_EN
  logic        redirect_taken;
  logic [31:0] trace_target;

  assign redirect_taken = (state == RUN) && !stall &&
                          (exc || jr || jump || branch_taken);

  // Mirror of the RUN priority, used only to report where a redirect lands.
  always_comb begin
    trace_target = pc_plus4;
    if (exc || jr_trap) begin
      trace_target = EXC_VEC;
    end else if (jr) begin
      trace_target = jr_addr;
    end else if (jump) begin
      trace_target = jump_target;
    end else if (branch_taken) begin
      trace_target = branch_target;
    end
  end

  // Count every non-sequential pc update taken while the pipe advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      redirect_count <= 32'h0000_0000;
    end else if (redirect_taken) begin
      redirect_count <= redirect_count + 32'd1;
    end
  end

`ifndef SYNTHESIS
  // Trace each redirect with its source pc, destination and cause.
  always @(posedge clk) begin
    if (reset && redirect_taken) begin
      $display("pc_sequencer_32 redirect %h -> %h cause=%s", pc, trace_target,
               exc ? "exc" : (jr_trap ? "jr_misalign" : (jr ? "jr" :
               (jump ? "jump" : "branch"))));
    end
  end
`endif
`endif

endmodule

// File: tb/tb_pc_sequencer_32.sv
// tb_pc_sequencer_32: directed self-checking bench for pc_sequencer_32.
`timescale 1ns/1ps

module tb_pc_sequencer_32;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_imm;
  logic        jump;
  logic [25:0] jump_index;
  logic        jr;
  logic [31:0] jr_addr;
  logic        exc;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic [31:0] epc;
  logic        misalign;
`ifdef PC_SEQ_TRACE_EN
  logic [31:0] redirect_count;
`endif

  int total;
  int bad;

  pc_sequencer_32 dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .exc          (exc),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .fetch_valid  (fetch_valid),
    .epc          (epc),
    .misalign     (misalign)
`ifdef PC_SEQ_TRACE_EN
    ,
    .redirect_count (redirect_count)
`endif
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall        = 1'b0;
    branch_taken = 1'b0;
    branch_imm   = 16'h0000;
    jump         = 1'b0;
    jump_index   = 26'h0;
    jr           = 1'b0;
    jr_addr      = 32'h0;
    exc          = 1'b0;
  endtask

  // Steer the PC to an aligned address with a single jr redirect.
  task automatic set_pc(input logic [31:0] addr);
    jr      = 1'b1;
    jr_addr = addr;
    tick();
    jr      = 1'b0;
    jr_addr = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b0;
    tick();
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_fv got=%b exp=0", fetch_valid); end
    total++; if (epc !== 32'h0) begin bad++; $display("[TB] FAIL reset_epc got=%h exp=%h", epc, 32'h0); end
    total++; if (misalign !== 1'b0) begin bad++; $display("[TB] FAIL reset_misalign got=%b exp=0", misalign); end
    reset = 1'b1;
    #1;
    total++; if (fetch_valid !== 1'b0 || pc !== 32'h0) begin bad++; $display("[TB] FAIL boot_cycle fv=%b pc=%h exp fv=0 pc=0", fetch_valid, pc); end
    tick();
    total++; if (fetch_valid !== 1'b1 || pc !== 32'h0) begin bad++; $display("[TB] FAIL first_fetch fv=%b pc=%h exp fv=1 pc=0", fetch_valid, pc); end
    tick();
    total++; if (pc !== 32'h4) begin bad++; $display("[TB] FAIL seq_1 got=%h exp=%h", pc, 32'h4); end
    tick();
    total++; if (pc !== 32'h8 || fetch_valid !== 1'b1) begin bad++; $display("[TB] FAIL seq_2 pc=%h fv=%b exp pc=8 fv=1", pc, fetch_valid); end
  endtask

  task automatic test_branch();
    set_pc(32'h0000_0010);
    total++; if (pc !== 32'h10) begin bad++; $display("[TB] FAIL set_pc_10 got=%h exp=%h", pc, 32'h10); end
    branch_taken = 1'b1;
    branch_imm   = 16'hFFFC;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h4) begin bad++; $display("[TB] FAIL branch_back got=%h exp=%h", pc, 32'h4); end
    set_pc(32'h0000_0010);
    branch_taken = 1'b1;
    branch_imm   = 16'h0003;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h20) begin bad++; $display("[TB] FAIL branch_fwd got=%h exp=%h", pc, 32'h20); end
  endtask

  task automatic test_jump_jr();
    set_pc(32'h4000_0010);
    jump       = 1'b1;
    jump_index = 26'h000_0040;
    jr         = 1'b1;
    jr_addr    = 32'h0000_1000;
    branch_taken = 1'b1;
    branch_imm   = 16'h0010;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h0000_1000) begin bad++; $display("[TB] FAIL jr_priority got=%h exp=%h", pc, 32'h0000_1000); end
    set_pc(32'h4000_0010);
    jump         = 1'b1;
    jump_index   = 26'h000_0040;
    branch_taken = 1'b1;
    branch_imm   = 16'h0010;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h4000_0100) begin bad++; $display("[TB] FAIL jump_only got=%h exp=%h", pc, 32'h4000_0100); end
  endtask

  task automatic test_misalign();
    set_pc(32'h0000_0024);
    jr      = 1'b1;
    jr_addr = 32'h0000_1002;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h80) begin bad++; $display("[TB] FAIL mis_pc got=%h exp=%h", pc, 32'h80); end
    total++; if (epc !== 32'h24) begin bad++; $display("[TB] FAIL mis_epc got=%h exp=%h", epc, 32'h24); end
    total++; if (misalign !== 1'b1) begin bad++; $display("[TB] FAIL mis_flag got=%b exp=1", misalign); end
    total++; if (fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL mis_bubble got=%b exp=0", fetch_valid); end
    // Everything is ignored during the trap bubble, exc included.
    exc  = 1'b1;
    jr   = 1'b1;
    jr_addr = 32'h0000_2003;
    jump = 1'b1;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h80 || fetch_valid !== 1'b1) begin bad++; $display("[TB] FAIL trap_exit pc=%h fv=%b exp pc=80 fv=1", pc, fetch_valid); end
    total++; if (epc !== 32'h24 || misalign !== 1'b1) begin bad++; $display("[TB] FAIL trap_ignore epc=%h mis=%b exp epc=24 mis=1", epc, misalign); end
    tick();
    total++; if (pc !== 32'h84 || misalign !== 1'b1) begin bad++; $display("[TB] FAIL after_trap pc=%h mis=%b exp pc=84 mis=1", pc, misalign); end
  endtask

  task automatic test_stall_exc();
    set_pc(32'h0000_0030);
    stall        = 1'b1;
    branch_taken = 1'b1;
    branch_imm   = 16'h0004;
    jr           = 1'b1;
    jr_addr      = 32'h0000_1002;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (pc !== 32'h30 || fetch_valid !== 1'b1) begin bad++; $display("[TB] FAIL stall_hold_%0d pc=%h fv=%b exp pc=30 fv=1", i, pc, fetch_valid); end
    end
    total++; if (misalign !== 1'b1 || epc !== 32'h24) begin bad++; $display("[TB] FAIL stall_no_trap mis=%b epc=%h exp mis=1 epc=24", misalign, epc); end
    clear_inputs();
    stall = 1'b1;
    exc   = 1'b1;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h80 || epc !== 32'h30) begin bad++; $display("[TB] FAIL stall_exc pc=%h epc=%h exp pc=80 epc=30", pc, epc); end
    total++; if (misalign !== 1'b0 || fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL stall_exc_flags mis=%b fv=%b exp mis=0 fv=0", misalign, fetch_valid); end
    tick();
  endtask

  task automatic test_exc_vs_jr();
    set_pc(32'h0000_0050);
    exc     = 1'b1;
    jr      = 1'b1;
    jr_addr = 32'h0000_1002;
    tick();
    clear_inputs();
    total++; if (pc !== 32'h80 || epc !== 32'h50 || misalign !== 1'b0) begin bad++; $display("[TB] FAIL exc_wins pc=%h epc=%h mis=%b exp pc=80 epc=50 mis=0", pc, epc, misalign); end
    tick();
  endtask

  task automatic test_wrap();
    set_pc(32'hFFFF_FFFC);
    total++; if (pc_plus4 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_plus4 got=%h exp=%h", pc_plus4, 32'h0); end
    tick();
    total++; if (pc !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got=%h exp=%h", pc, 32'h0); end
    total++; if (pc_plus4 !== 32'h4) begin bad++; $display("[TB] FAIL plus4_zero got=%h exp=%h", pc_plus4, 32'h4); end
  endtask

  task automatic test_async_reset();
    set_pc(32'h0000_0100);
    #2;
    reset = 1'b0;
    #1;
    total++; if (pc !== 32'h0 || fetch_valid !== 1'b0) begin bad++; $display("[TB] FAIL async_reset pc=%h fv=%b exp pc=0 fv=0", pc, fetch_valid); end
    total++; if (epc !== 32'h0 || misalign !== 1'b0) begin bad++; $display("[TB] FAIL async_reset_regs epc=%h mis=%b exp epc=0 mis=0", epc, misalign); end
    tick();
    reset = 1'b1;
    tick();
    total++; if (pc !== 32'h0 || fetch_valid !== 1'b1) begin bad++; $display("[TB] FAIL reboot pc=%h fv=%b exp pc=0 fv=1", pc, fetch_valid); end
  endtask

  // Scenario sequence followed by the single summary line.
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_branch();
    test_jump_jr();
    test_misalign();
    test_stall_exc();
    test_exc_vs_jr();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
